// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared state type, blanking constants and digit-enable helper for the segment scanner
package seg_scan_pkg;
  typedef enum logic {S_BLANK, S_ON} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;
  localparam int NUM_DIGITS = 4;
  function automatic logic [3:0] an_sel(input logic [1:0] d);
    return ~(4'b0001 << d);
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: per-slot tick counter with blank-end, next-to-last and slot-end strobes
module scan_tick_gen #(
  parameter int DIGIT_TICKS = 12500,
  parameter int BLANK_TICKS = 500
) (
  input  logic CLOCK_50,
  input  logic resetn,
  output logic blank_done,
  output logic slot_near,
  output logic slot_done
);
  localparam int W = $clog2(DIGIT_TICKS);
  logic [W-1:0] cnt;
  assign blank_done = cnt == W'(BLANK_TICKS - 1);
  assign slot_near = cnt == W'(DIGIT_TICKS - 2);
  assign slot_done = cnt == W'(DIGIT_TICKS - 1);
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= slot_done ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner with blanking and frame-synchronous pattern loading
// Optional SEG_SCAN_BRIGHTNESS_PWM_EN adds a brightness input that PWM-gates the digit enables.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIGIT_TICKS = 12500,
  parameter int BLANK_TICKS = 500
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
  input  logic [3:0] brightness,
`endif
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [6:0] pat0,
  input  logic [6:0] pat1,
  input  logic [6:0] pat2,
  input  logic [6:0] pat3,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic       frame_tick
);
  state_t state, state_n;
  logic [1:0] digit, digit_n;
  logic [NUM_DIGITS-1:0][6:0] disp, shadow;
  logic blank_done, slot_near, slot_done, en;
  scan_tick_gen #(.DIGIT_TICKS(DIGIT_TICKS), .BLANK_TICKS(BLANK_TICKS)) u_tick (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .blank_done(blank_done),
    .slot_near (slot_near),
    .slot_done (slot_done)
  );
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0] pwm_cnt;
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + 4'd1;
  // outputs are registered, so gate on the value the PWM counter will hold next cycle
  assign en = 4'(pwm_cnt + 4'd1) <= brightness;
`else
  assign en = 1'b1;
`endif
  always_comb begin
    state_n = state == S_BLANK ? (blank_done ? S_ON : S_BLANK) : (slot_done ? S_BLANK : S_ON);
    digit_n = state == S_ON && slot_done ? digit + 2'd1 : digit;
  end
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state      <= S_BLANK;
      digit      <= '0;
      disp       <= {NUM_DIGITS{SEG_BLANK}};
      shadow     <= {NUM_DIGITS{SEG_BLANK}};
      load_ready <= 1'b1;
      SEG        <= SEG_BLANK;
      AN         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      digit      <= digit_n;
      SEG        <= state_n == S_ON ? disp[digit_n] : SEG_BLANK;
      AN         <= state_n == S_ON && en ? an_sel(digit_n) : AN_OFF;
      frame_tick <= digit == 2'(NUM_DIGITS - 1) && slot_near;
      // a transfer landing on the frame boundary fills the shadow and waits a whole frame
      if (load_valid && load_ready) begin
        shadow     <= {pat3, pat2, pat1, pat0};
        load_ready <= 1'b0;
      end else if (frame_tick && !load_ready) begin
        disp       <= shadow;
        load_ready <= 1'b1;
      end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench; stimulus queues expected frames, a negedge monitor checks every cycle
module tb_seg_scan_driver;
  localparam int DT = 8, BT = 2, FR = 4 * DT;
  logic CLOCK_50 = 1'b0, resetn = 1'b0, load_valid = 1'b0;
  logic [6:0] pat0 = '0, pat1 = '0, pat2 = '0, pat3 = '0;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic load_ready, frame_tick;
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
  logic [3:0] brightness = 4'd15;
`endif
  seg_scan_driver #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
    .brightness(brightness),
`endif
    .load_valid(load_valid),
    .load_ready(load_ready),
    .pat0      (pat0),
    .pat1      (pat1),
    .pat2      (pat2),
    .pat3      (pat3),
    .SEG       (SEG),
    .AN        (AN),
    .frame_tick(frame_tick)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  typedef struct {
    int frame;
    logic [3:0][6:0] pat;
  } exp_t;
  exp_t q[$];
  int c = 0, checks = 0, errors = 0, pos, dg;
  logic [3:0][6:0] shown = {4{7'h7F}};
  logic [3:0] ean;
  logic [6:0] eseg;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask
  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      chk("rst_seg", SEG, 7'h7F);
      chk("rst_an", AN, 4'hF);
      chk("rst_frame_tick", frame_tick, 1'b0);
      chk("rst_load_ready", load_ready, 1'b1);
      c = 0;
      shown = {4{7'h7F}};
      q.delete();
    end else begin
      if (c % FR == 0)
        while (q.size() > 0 && q[0].frame == c / FR) begin
          shown = q[0].pat;
          q.delete(0);
        end
      pos = c % DT;
      dg = (c / DT) % 4;
      ean = 4'b0001 << dg;
      ean = pos < BT ? 4'hF : ~ean;
      eseg = pos < BT ? 7'h7F : shown[dg];
      chk("an", AN, ean);
      chk("seg", SEG, eseg);
      chk("frame_tick", frame_tick, c % FR == FR - 1);
      c++;
    end
  end
  task automatic go(input int k);
    while (c != k + 1) begin
      @(negedge CLOCK_50);
      #1;
    end
  endtask
  task automatic load(input logic [6:0] p0, p1, p2, p3, input int fr);
    {pat0, pat1, pat2, pat3} = {p0, p1, p2, p3};
    load_valid = 1'b1;
    if (fr >= 0) q.push_back('{fr, {p3, p2, p1, p0}});
    @(negedge CLOCK_50);
    #1;
    load_valid = 1'b0;
    {pat0, pat1, pat2, pat3} = '0;
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #2 resetn = 1'b1;
    go(5);
    chk("ready_idle", load_ready, 1'b1);
    load(7'h40, 7'h79, 7'h24, 7'h30, 1);
    go(6);
    chk("ready_after_load", load_ready, 1'b0);
    go(10);
    load(7'h12, 7'h34, 7'h56, 7'h0F, -1);
    go(31);
    chk("ready_frame_tick", load_ready, 1'b0);
    go(32);
    chk("ready_reassert", load_ready, 1'b1);
    go(63);
    chk("ready_before_boundary_load", load_ready, 1'b1);
    load(7'h06, 7'h5B, 7'h4F, 7'h66, 3);
    go(64);
    chk("ready_boundary_load", load_ready, 1'b0);
    go(95);
    chk("ready_held_frame2", load_ready, 1'b0);
    go(96);
    chk("ready_after_frame2", load_ready, 1'b1);
    go(100);
    load(7'h6D, 7'h7D, 7'h07, 7'h6F, -1);
    go(104);
    chk("ready_pending", load_ready, 1'b0);
    go(115);
    resetn = 1'b0;
    #1;
    chk("async_rst_seg", SEG, 7'h7F);
    chk("async_rst_an", AN, 4'hF);
    chk("async_rst_frame_tick", frame_tick, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #2 resetn = 1'b1;
    go(0);
    chk("ready_after_rst", load_ready, 1'b1);
    go(70);
    chk("ready_end", load_ready, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
